uart_rx_fifo: RTL and testbench

Receive side of the SoC UART controller. Samples the asynchronous serial line driven off-chip (8 data bits LSB-first, optional even parity, 1 stop bit) and reconstructs bytes. Bytes are buffered in a small FIFO and presented to the bus-facing register logic through a valid/ready handshake. Sticky framing and overflow error flags are kept for the status register.

---
 rtl/uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive path: two-flop input synchronizer, bit-timing FSM (8N1 or 8E1)
// and a small byte FIFO with a registered head entry and sticky error flags.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [DIV_W-1:0]         divisor,
    input  logic                     parity_en,
    input  logic                     rx,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     framing_err,
    output logic                     overflow,
    input  logic                     clear_errors
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rxState_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             rxs;

    rxState_t         state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] perMax_q;
    logic [7:0]       shift_q;
    logic [2:0]       bitIdx_q;
    logic             perr_q;

    logic [DIV_W-1:0] divClamp;
    logic [DIV_W-1:0] halfCnt;
    logic             stopSample;
    logic             pushReq;
    logic             frameErrSet;
    logic [8:0]       wrData;

    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       head_q;
    logic [8:0]       head_d;
    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    rdPtr_d;
    logic [AW-1:0]    rdPtrInc;
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    wrPtr_d;
    logic [LW-1:0]    count_q;
    logic [LW-1:0]    count_d;
    logic             full;
    logic             pop;
    logic             pushAccept;
    logic             overflowSet;

    logic             framing_q;
    logic             overflow_q;

    assign rxs = sync2_q;

    // Very short divisors cannot place a mid-bit sample, so they are clamped to 3.
    assign divClamp = (divisor < DIV_W'(3)) ? DIV_W'(3) : divisor;
    // floor(P/2)-1 with P = divClamp+1, i.e. floor((d+1)/2)-1.
    assign halfCnt  = (divClamp >> 1) + DIV_W'(divClamp[0]) - DIV_W'(1);

    assign stopSample  = (state_q == S_STOP) && (cnt_q == '0);
    assign pushReq     = stopSample && rxs;
    assign frameErrSet = stopSample && !rxs;
    assign wrData      = {perr_q, shift_q};

    // Bring the asynchronous serial line into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: a down-counter times each bit and the line is sampled when it hits zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            perMax_q <= '0;
            shift_q  <= '0;
            bitIdx_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        perMax_q <= divClamp;
                        cnt_q    <= halfCnt;
                        bitIdx_q <= '0;
                        perr_q   <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (rxs) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= perMax_q;
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q  <= {rxs, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 1'b1;
                        cnt_q    <= perMax_q;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= parity_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        perr_q  <= rxs ^ (^shift_q);
                        cnt_q   <= perMax_q;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign full        = (count_q == LW'(DEPTH));
    assign pop         = (count_q != '0) && rd_ready;
    assign pushAccept  = pushReq && (!full || pop);
    assign overflowSet = pushReq && full && !pop;
    assign rdPtrInc    = rdPtr_q + 1'b1;

    // FIFO bookkeeping; the head register is refilled from the array or bypassed from the write.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        head_d  = head_q;
        if (pushAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtrInc;
        end
        if (pushAccept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !pushAccept) begin
            count_d = count_q - 1'b1;
        end
        if ((count_q == '0) || (pop && (count_q == LW'(1)))) begin
            head_d = wrData;
        end else if (pop) begin
            head_d = mem_q[rdPtrInc];
        end
    end

    // FIFO pointer, occupancy and head state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            head_q  <= '0;
        end else begin
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            head_q  <= head_d;
        end
    end

    // Storage array; contents are meaningless after reset because occupancy is cleared.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem_q[wrPtr_q] <= wrData;
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            framing_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            framing_q  <= (framing_q  & ~clear_errors) | frameErrSet;
            overflow_q <= (overflow_q & ~clear_errors) | overflowSet;
        end
    end

    assign rd_valid      = (count_q != '0);
    assign rd_data       = head_q[7:0];
    assign rd_parity_err = head_q[8];
    assign level         = count_q;
    assign framing_err   = framing_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=4, divisor=5, bit period 6 cycles).
module tb_uart_rx_fifo;

    logic        clk;
    logic        nreset;
    logic [15:0] divisor;
    logic        parity_en;
    logic        rx;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_parity_err;
    logic        rd_ready;
    logic [2:0]  level;
    logic        framing_err;
    logic        overflow;
    logic        clear_errors;

    int compared;
    int mismatched;

    uart_rx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .divisor       (divisor),
        .parity_en     (parity_en),
        .rx            (rx),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_ready      (rd_ready),
        .level         (level),
        .framing_err   (framing_err),
        .overflow      (overflow),
        .clear_errors  (clear_errors)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one frame on rx, one bit per 6 negedges; rd_ready is pulsed on cycle popAt (-1 = never)
    task automatic sendFrame(input logic [7:0] data, input logic usePar, input logic parBit,
                             input logic stopBit, input int popAt);
        logic [10:0] bits;
        int nBits;
        bits     = '1;
        bits[0]  = 1'b0;
        bits[8:1] = data;
        if (usePar) begin
            bits[9]  = parBit;
            bits[10] = stopBit;
            nBits    = 11;
        end else begin
            bits[9]  = stopBit;
            nBits    = 10;
        end
        for (int i = 0; i < nBits; i++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                rx       = bits[i];
                rd_ready = ((6 * i + c) == popAt);
            end
        end
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    task automatic doPop();
        @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle(3);
        compared++;
        if (rd_valid !== 1'b0 || level !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_fifo: actual valid=%b level=%0d required valid=0 level=0", rd_valid, level);
        end
        compared++;
        if (framing_err !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: actual fe=%b ov=%b required 0 0", framing_err, overflow);
        end
        nreset = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int waited;
        parity_en = 1'b1;
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
        waited = 0;
        while (rd_valid !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (rd_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL a5_latency: actual valid=%b required valid=1 within 70 cycles", rd_valid);
        end
        compared++;
        if (rd_data !== 8'hA5 || rd_parity_err !== 1'b0 || level !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL a5_data: actual data=%h perr=%b level=%0d required a5 0 1",
                     rd_data, rd_parity_err, level);
        end
        doPop();
        compared++;
        if (level !== 3'd0 || rd_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL a5_pop: actual level=%0d valid=%b required 0 0", level, rd_valid);
        end
        rd_ready = 1'b1;
        idle(2);
        rd_ready = 1'b0;
        compared++;
        if (level !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL empty_pop: actual level=%0d required 0", level);
        end
        idle(6);
    endtask

    task automatic test_parity_err();
        parity_en = 1'b1;
        sendFrame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        idle(2);
        compared++;
        if (rd_data !== 8'h3C || rd_parity_err !== 1'b1 || framing_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL 3c_parity: actual data=%h perr=%b fe=%b required 3c 1 0",
                     rd_data, rd_parity_err, framing_err);
        end
        doPop();
        idle(6);
    endtask

    task automatic test_framing();
        parity_en = 1'b0;
        sendFrame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        idle(12);
        rx = 1'b1;
        idle(12);
        compared++;
        if (framing_err !== 1'b1 || level !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL break_frame: actual fe=%b level=%0d required fe=1 level=0", framing_err, level);
        end
        sendFrame(8'h12, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        compared++;
        if (level !== 3'd1 || rd_data !== 8'h12 || framing_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL after_break: actual level=%0d data=%h fe=%b required 1 12 1",
                     level, rd_data, framing_err);
        end
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        compared++;
        if (framing_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_fe: actual fe=%b required 0", framing_err);
        end
        doPop();
        idle(6);
    endtask

    task automatic test_glitch();
        parity_en = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
        idle(20);
        compared++;
        if (rd_valid !== 1'b0 || level !== 3'd0 || framing_err !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch: actual valid=%b level=%0d fe=%b ov=%b required all 0",
                     rd_valid, level, framing_err, overflow);
        end
        sendFrame(8'h81, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        compared++;
        if (rd_data !== 8'h81 || rd_parity_err !== 1'b0 || level !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL after_glitch: actual data=%h perr=%b level=%0d required 81 0 1",
                     rd_data, rd_parity_err, level);
        end
        doPop();
        idle(6);
    endtask

    task automatic test_overflow();
        logic [7:0] expOrder [4];
        parity_en = 1'b0;
        rd_ready  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sendFrame(8'(k), 1'b0, 1'b0, 1'b1, -1);
            idle(6);
        end
        compared++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fill: actual level=%0d ov=%b required 4 0", level, overflow);
        end
        sendFrame(8'h05, 1'b0, 1'b0, 1'b1, -1);
        idle(6);
        compared++;
        if (level !== 3'd4 || overflow !== 1'b1 || rd_data !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL overflow: actual level=%0d ov=%b head=%h required 4 1 01",
                     level, overflow, rd_data);
        end
        // Push of the stop-bit sample lands on the posedge between negedge 59 and 60
        sendFrame(8'h06, 1'b0, 1'b0, 1'b1, 59);
        idle(2);
        compared++;
        if (level !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL full_pushpop: actual level=%0d required 4", level);
        end
        expOrder[0] = 8'h02;
        expOrder[1] = 8'h03;
        expOrder[2] = 8'h04;
        expOrder[3] = 8'h06;
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (rd_valid !== 1'b1 || rd_data !== expOrder[k]) begin
                mismatched++;
                $display("[TB] FAIL drain_%0d: actual valid=%b data=%h required 1 %h",
                         k, rd_valid, rd_data, expOrder[k]);
            end
            doPop();
        end
        compared++;
        if (level !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL drained: actual level=%0d required 0", level);
        end
        idle(6);
    endtask

    task automatic test_reset_midframe();
        logic [3:0] partial;
        parity_en = 1'b0;
        sendFrame(8'h44, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        compared++;
        if (level !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL pre_reset: actual level=%0d required 1", level);
        end
        // Start bit then data bits of 0x77 LSB-first: 1,1,1,0 (abandoned in bit 3)
        partial = 4'b0111;
        @(negedge clk);
        rx = 1'b0;
        idle(5);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            rx = partial[b];
            idle((b == 3) ? 2 : 5);
        end
        nreset = 1'b0;
        rx     = 1'b1;
        idle(3);
        nreset = 1'b1;
        idle(12);
        compared++;
        if (level !== 3'd0 || rd_valid !== 1'b0 || framing_err !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: actual level=%0d valid=%b fe=%b ov=%b required all 0",
                     level, rd_valid, framing_err, overflow);
        end
        sendFrame(8'h9A, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        compared++;
        if (level !== 3'd1 || rd_data !== 8'h9A || framing_err !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL after_reset: actual level=%0d data=%h fe=%b ov=%b required 1 9a 0 0",
                     level, rd_data, framing_err, overflow);
        end
    endtask

    // Scenario sequence
    initial begin
        compared     = 0;
        mismatched   = 0;
        nreset       = 1'b0;
        divisor      = 16'd5;
        parity_en    = 1'b0;
        rx           = 1'b1;
        rd_ready     = 1'b0;
        clear_errors = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_framing();
        test_glitch();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
